axs_wr_fsm: RTL and testbench

AXI4 write-channel slave controller for the `axs_s0` port: the write-direction counterpart of the read-side FSM.
- Accepts a write address (AW), absorbs the write-data burst (W) into the input FIFO, and returns a write response (B).
- Write data itself bypasses this block and goes straight to the FIFO data input; this block only sequences handshakes, selects what the FIFO captures, and checks burst framing.

---
 rtl/axs_wr_fsm_pkg.sv | 21 ++
 rtl/axs_wr_fsm.sv | 154 +++++++++++++++
 tb/tb_axs_wr_fsm.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axs_wr_fsm_pkg.sv
// Shared types and codes for the axs_s0 write-channel controller.
package axs_wr_fsm_pkg;

  typedef enum logic [4:0] {
    S_INIT  = 5'h01,
    S_IDLE  = 5'h02,
    S_DATA  = 5'h04,
    S_DRAIN = 5'h08,
    S_RESP  = 5'h10
  } wr_state_e;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_DATA = 2'b01;
  localparam logic [1:0] SEL_HDR  = 2'b10;

  localparam logic [1:0] BURST_RSVD = 2'b11;

endpackage

// File: rtl/axs_wr_fsm.sv
// AXI4 write-channel slave controller for axs_s0: sequences AW/W/B
// handshakes, steers input FIFO pushes and checks burst framing.
module axs_wr_fsm
  import axs_wr_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  axs_s0_awid,
  input  logic [31:0] axs_s0_awaddr,
  input  logic [7:0]  axs_s0_awlen,
  input  logic [2:0]  axs_s0_awsize,
  input  logic [1:0]  axs_s0_awburst,
  input  logic        axs_s0_awvalid,
  output logic        axs_s0_awready,
  input  logic        axs_s0_wlast,
  input  logic        axs_s0_wvalid,
  output logic        axs_s0_wready,
  output logic [3:0]  axs_s0_bid,
  output logic [1:0]  axs_s0_bresp,
  output logic        axs_s0_bvalid,
  input  logic        axs_s0_bready,
  input  logic        in_fifo_full,
  output logic        in_fifo_push,
  output logic [1:0]  in_fifo_push_sel
);

  wr_state_e state, nxt;

  logic [3:0]  awid_q;
  logic [31:0] awaddr_q;
  logic [7:0]  awlen_q;
  logic [2:0]  awsize_q;
  logic [1:0]  awburst_q;
  logic [7:0]  beats_left;
  logic        err;

  logic clr;
  logic cap;
  logic dec;
  logic set_err;

  always_comb begin
    nxt              = state;
    axs_s0_awready   = 1'b0;
    axs_s0_wready    = 1'b0;
    axs_s0_bvalid    = 1'b0;
    axs_s0_bid       = '0;
    axs_s0_bresp     = BRESP_OKAY;
    in_fifo_push     = 1'b0;
    in_fifo_push_sel = SEL_NONE;
    clr              = 1'b0;
    cap              = 1'b0;
    dec              = 1'b0;
    set_err          = 1'b0;

    case (state)
      S_INIT: begin
        clr = 1'b1;
        nxt = S_IDLE;
      end
      S_IDLE: begin
        axs_s0_awready = ~in_fifo_full;
        if (axs_s0_awvalid && !in_fifo_full) begin
          in_fifo_push     = 1'b1;
          in_fifo_push_sel = SEL_HDR;
          cap              = 1'b1;
          nxt = (axs_s0_awburst == BURST_RSVD)
              ? S_DRAIN : S_DATA;
        end
      end
      S_DATA: begin
        axs_s0_wready = ~in_fifo_full;
        if (axs_s0_wvalid && !in_fifo_full) begin
          in_fifo_push     = 1'b1;
          in_fifo_push_sel = SEL_DATA;
          // Zero check first: the counter never wraps below 0.
          if (beats_left == 8'd0) begin
            if (axs_s0_wlast) begin
              nxt = S_RESP;
            end else begin
              set_err = 1'b1;
              nxt     = S_DRAIN;
            end
          end else if (axs_s0_wlast) begin
            set_err = 1'b1;
            nxt     = S_RESP;
          end else begin
            dec = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        axs_s0_wready = 1'b1;
        if (axs_s0_wvalid && axs_s0_wlast)
          nxt = S_RESP;
      end
      S_RESP: begin
        axs_s0_bvalid = 1'b1;
        axs_s0_bid    = awid_q;
        axs_s0_bresp  = err ? BRESP_SLVERR : BRESP_OKAY;
        if (axs_s0_bready)
          nxt = S_IDLE;
      end
      default: begin
        nxt = S_INIT;
      end
    endcase

    // Outputs stay quiet while reset is held, whatever the state.
    if (reset) begin
      axs_s0_awready   = 1'b0;
      axs_s0_wready    = 1'b0;
      axs_s0_bvalid    = 1'b0;
      axs_s0_bid       = '0;
      axs_s0_bresp     = BRESP_OKAY;
      in_fifo_push     = 1'b0;
      in_fifo_push_sel = SEL_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_INIT;
    else
      state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      awid_q     <= '0;
      awaddr_q   <= '0;
      awlen_q    <= '0;
      awsize_q   <= '0;
      awburst_q  <= '0;
      beats_left <= '0;
      err        <= 1'b0;
    end else begin
      if (cap) begin
        awid_q     <= axs_s0_awid;
        awaddr_q   <= axs_s0_awaddr;
        awlen_q    <= axs_s0_awlen;
        awsize_q   <= axs_s0_awsize;
        awburst_q  <= axs_s0_awburst;
        beats_left <= axs_s0_awlen;
        err        <= (axs_s0_awburst == BURST_RSVD);
      end
      if (dec)
        beats_left <= beats_left - 8'd1;
      if (set_err)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axs_wr_fsm.sv
// Directed bench for axs_wr_fsm: framing, backpressure, errors
// and mid-burst reset.
module tb_axs_wr_fsm;
  import axs_wr_fsm_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        full;
  logic        push;
  logic [1:0]  sel;

  int total = 0;
  int bad   = 0;
  int pushes = 0;
  int base;

  always #5 clk = ~clk;

  axs_wr_fsm dut (
    .clk              (clk),
    .reset            (reset),
    .axs_s0_awid      (awid),
    .axs_s0_awaddr    (awaddr),
    .axs_s0_awlen     (awlen),
    .axs_s0_awsize    (awsize),
    .axs_s0_awburst   (awburst),
    .axs_s0_awvalid   (awvalid),
    .axs_s0_awready   (awready),
    .axs_s0_wlast     (wlast),
    .axs_s0_wvalid    (wvalid),
    .axs_s0_wready    (wready),
    .axs_s0_bid       (bid),
    .axs_s0_bresp     (bresp),
    .axs_s0_bvalid    (bvalid),
    .axs_s0_bready    (bready),
    .in_fifo_full     (full),
    .in_fifo_push     (push),
    .in_fifo_push_sel (sel)
  );

  always @(posedge clk)
    if (push) pushes <= pushes + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_aw(input logic [3:0] id,
                       input logic [7:0] len,
                       input logic [1:0] burst);
    awvalid = 1'b1;
    awid    = id;
    awlen   = len;
    awburst = burst;
    awaddr  = 32'h1000_0000 + {28'd0, id};
    awsize  = 3'd2;
    #2;
    chk("aw_ready", awready, 1);
    chk("aw_push", push, 1);
    chk("aw_sel", sel, SEL_HDR);
    tick();
    awvalid = 1'b0;
  endtask

  task automatic beat(input logic last,
                      input logic exp_wready,
                      input logic exp_push);
    wvalid = 1'b1;
    wlast  = last;
    #2;
    chk("w_ready", wready, exp_wready);
    chk("w_push", push, exp_push);
    chk("w_sel", sel, exp_push ? SEL_DATA : SEL_NONE);
    chk("w_awready", awready, 0);
    chk("w_fullpush", push & full, 0);
    tick();
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic stall();
    wvalid = 1'b1;
    full   = 1'b1;
    #2;
    chk("stall_wready", wready, 0);
    chk("stall_push", push, 0);
    tick();
    wvalid = 1'b0;
    full   = 1'b0;
  endtask

  task automatic resp(input logic [3:0] id,
                      input logic [1:0] r);
    bready = 1'b1;
    #2;
    chk("b_valid", bvalid, 1);
    chk("b_id", bid, id);
    chk("b_resp", bresp, r);
    chk("b_awready", awready, 0);
    tick();
    bready = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    awid    = '0;
    awaddr  = '0;
    awlen   = '0;
    awsize  = '0;
    awburst = 2'b01;
    awvalid = 1'b0;
    wlast   = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    full    = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_push", push, 0);
    chk("rst_bid", bid, 0);
    reset = 1'b0;
    #2;
    chk("init_awready", awready, 0);
    tick();
    #2;
    chk("idle_awready", awready, 1);

    // W before AW is held off
    wvalid = 1'b1;
    wlast  = 1'b1;
    #2;
    chk("idle_wready", wready, 0);
    chk("idle_wpush", push, 0);
    wvalid = 1'b0;
    wlast  = 1'b0;

    // AW while FIFO full: no header push
    full    = 1'b1;
    awvalid = 1'b1;
    #1;
    chk("awfull_ready", awready, 0);
    chk("awfull_push", push, 0);
    tick();
    full = 1'b0;

    // Single beat OKAY
    base = pushes;
    do_aw(4'h3, 8'd0, 2'b01);
    beat(1'b1, 1'b1, 1'b1);
    resp(4'h3, BRESP_OKAY);
    #2;
    chk("t1_awready", awready, 1);
    chk("t1_bvalid", bvalid, 0);
    chk("t1_bid", bid, 0);
    chk("t1_pushes", pushes - base, 2);

    // 4-beat burst, FIFO full on DATA cycles 2-3
    base = pushes;
    do_aw(4'h1, 8'd3, 2'b01);
    beat(1'b0, 1'b1, 1'b1);
    stall();
    stall();
    beat(1'b0, 1'b1, 1'b1);
    beat(1'b0, 1'b1, 1'b1);
    beat(1'b1, 1'b1, 1'b1);
    resp(4'h1, BRESP_OKAY);
    chk("t2_pushes", pushes - base, 5);

    // Early wlast on beat 2 of 4
    base = pushes;
    do_aw(4'h2, 8'd3, 2'b01);
    beat(1'b0, 1'b1, 1'b1);
    beat(1'b1, 1'b1, 1'b1);
    resp(4'h2, BRESP_SLVERR);
    chk("t3_pushes", pushes - base, 3);

    // Missing wlast: 2-beat burst, wlast on beat 4
    base = pushes;
    do_aw(4'h4, 8'd1, 2'b01);
    beat(1'b0, 1'b1, 1'b1);
    beat(1'b0, 1'b1, 1'b1);
    full   = 1'b1;
    wvalid = 1'b1;
    #2;
    chk("drain_wready", wready, 1);
    chk("drain_push", push, 0);
    tick();
    full   = 1'b0;
    wvalid = 1'b0;
    beat(1'b1, 1'b1, 1'b0);
    resp(4'h4, BRESP_SLVERR);
    chk("t4_pushes", pushes - base, 3);

    // Reserved burst type, B held under bready low
    base = pushes;
    do_aw(4'h6, 8'd1, BURST_RSVD);
    beat(1'b0, 1'b1, 1'b0);
    beat(1'b1, 1'b1, 1'b0);
    #2;
    chk("hold_bvalid", bvalid, 1);
    chk("hold_bresp", bresp, BRESP_SLVERR);
    tick();
    resp(4'h6, BRESP_SLVERR);
    chk("t5_pushes", pushes - base, 1);

    // Reset during beat 2 of an 8-beat burst
    do_aw(4'h7, 8'd7, 2'b01);
    beat(1'b0, 1'b1, 1'b1);
    base   = pushes;
    reset  = 1'b1;
    wvalid = 1'b1;
    #2;
    chk("mrst_wready", wready, 0);
    chk("mrst_push", push, 0);
    chk("mrst_bvalid", bvalid, 0);
    tick();
    reset  = 1'b0;
    wvalid = 1'b0;
    #2;
    chk("mrst_init_awready", awready, 0);
    chk("mrst_init_bvalid", bvalid, 0);
    tick();
    #2;
    chk("mrst_idle_awready", awready, 1);
    chk("mrst_idle_bvalid", bvalid, 0);
    do_aw(4'h5, 8'd0, 2'b01);
    beat(1'b1, 1'b1, 1'b1);
    resp(4'h5, BRESP_OKAY);
    chk("t6_pushes", pushes - base, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
